// File: rtl/shifter_pkg.sv
// Shared types and helpers for the iterative shift unit (seq_shifter).
package shifter_pkg;

  // Operation codes. 3'b110 and 3'b111 are reserved and execute as PASS.
  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_LSL  = 3'b001,
    OP_LSR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101
  } shift_op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Width of the shift-amount field for a given operand width.
  function automatic int amt_width(input int width);
    return $clog2(width);
  endfunction

  // True for opcodes that actually move bits (LSL..ROR); PASS and
  // reserved codes complete without entering SHIFT.
  function automatic logic op_moves_bits(input logic [2:0] op);
    logic r;
    case (op)
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-position shift/rotate of one operand.
// out_bit is the bit that leaves the word on this step (0 for PASS/reserved).
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] next_data,
  output logic             out_bit
);

  // One-position step selected by the opcode.
  always_comb begin
    next_data = data;
    out_bit   = 1'b0;
    case (op)
      OP_LSL: begin
        next_data = {data[WIDTH-2:0], 1'b0};
        out_bit   = data[WIDTH-1];
      end
      OP_LSR: begin
        next_data = {1'b0, data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      OP_ASR: begin
        next_data = {data[WIDTH-1], data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      OP_ROL: begin
        next_data = {data[WIDTH-2:0], data[WIDTH-1]};
        out_bit   = data[WIDTH-1];
      end
      OP_ROR: begin
        next_data = {data[0], data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      default: begin
        next_data = data;
        out_bit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: iterative shift/rotate unit, one bit position per clock,
// valid/ready on both sides, no bypass from DONE back to accept.
// Optional feature macro: SHIFTER_CARRY_EN adds the out_carry port and
// the carry register (last bit shifted/rotated out).
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = amt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SHIFTER_CARRY_EN
  output logic             out_carry,
`endif
  output logic             busy
);

  localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);
  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

  shift_state_e     r_state;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_next_data;
  logic             w_accept;
  logic             w_direct;

`ifdef SHIFTER_CARRY_EN
  logic             r_carry;
  logic             w_step_bit;
`else
  logic             w_step_bit_unused;
`endif

  // in_ready is only ever high in IDLE, so it alone qualifies the accept.
  assign w_accept = in_valid && r_in_ready;
  // Zero amount or a non-moving opcode finishes without a SHIFT phase.
  assign w_direct = (in_amt == CNT_ZERO) || !op_moves_bits(in_op);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data      (r_data),
    .op        (r_op),
    .next_data (w_next_data),
`ifdef SHIFTER_CARRY_EN
    .out_bit   (w_step_bit)
`else
    .out_bit   (w_step_bit_unused)
`endif
  );

  // Control FSM with working, op, count and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= {WIDTH{1'b0}};
      r_op        <= 3'b000;
      r_cnt       <= CNT_ZERO;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SHIFTER_CARRY_EN
      r_carry     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data     <= in_data;
            r_op       <= in_op;
            r_cnt      <= in_amt;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef SHIFTER_CARRY_EN
            r_carry    <= 1'b0;
`endif
            if (w_direct) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= ST_SHIFT;
              r_out_valid <= 1'b0;
            end
          end else begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_data <= w_next_data;
          r_cnt  <= r_cnt - CNT_ONE;
`ifdef SHIFTER_CARRY_EN
          r_carry <= w_step_bit;
`endif
          if (r_cnt == CNT_ONE) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_state     <= ST_SHIFT;
            r_out_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          // Result and carry are frozen here until the consumer takes them.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_in_ready  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign busy      = r_busy;
`ifdef SHIFTER_CARRY_EN
  assign out_carry = r_carry;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=16).
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_op;
  logic [3:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
`ifdef SHIFTER_CARRY_EN
  logic        out_carry;
`endif

  int checks;
  int failures;

  seq_shifter #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SHIFTER_CARRY_EN
    .out_carry (out_carry),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency from the accept edge, optionally
  // hold back-pressure, then complete the output handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] data,
                        input logic [3:0] amt, input logic [15:0] exp_data,
                        input logic exp_carry, input int exp_lat, input int hold);
    int n;
    int lat;
    logic ready_low;
    logic stable;
    logic [15:0] held;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = data;
    in_amt    = amt;
    out_ready = 1'b0;
    tick();  // accept edge
    in_valid = 1'b0;
    in_data  = ~data;
    in_op    = 3'b001;
    in_amt   = ~amt;
    lat = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_low = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) ready_low = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_inrdy_low"}, ready_low, 1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_busy"}, busy, 1);
`ifdef SHIFTER_CARRY_EN
    check({tag, "_carry"}, out_carry, exp_carry);
`else
    if (exp_carry === 1'bx) $display("note: unexpected x carry in %s", tag);
`endif
    held = out_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
`ifdef SHIFTER_CARRY_EN
      if (out_carry !== exp_carry) stable = 1'b0;
`endif
    end
    if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, out_valid, 0);
    check({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_op     = 3'b000;
    in_amt    = 4'h0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_busy", busy, 0);
`ifdef SHIFTER_CARRY_EN
    check("rst_carry", out_carry, 0);
`endif
    rst_n = 1'b1;
    check("rel_in_ready_pre", in_ready, 0);
    tick();
    check("rel_in_ready", in_ready, 1);

    // Main function, hand-computed vectors
    run_op("lsl1",   3'b001, 16'h8001, 4'd1,  16'h0002, 1'b1, 2,  0);
    run_op("asr3",   3'b011, 16'h8000, 4'd3,  16'hF000, 1'b0, 4,  0);
    run_op("lsr3",   3'b010, 16'h8000, 4'd3,  16'h1000, 1'b0, 4,  0);
    run_op("lsr15",  3'b010, 16'h8000, 4'd15, 16'h0001, 1'b0, 16, 0);
    run_op("rol1",   3'b100, 16'h8000, 4'd1,  16'h0001, 1'b1, 2,  0);
    run_op("ror4",   3'b101, 16'h0001, 4'd4,  16'h1000, 1'b0, 5,  0);
    run_op("rsv7",   3'b111, 16'hABCD, 4'd5,  16'hABCD, 1'b0, 1,  0);
    run_op("lsl0",   3'b001, 16'h8001, 4'd0,  16'h8001, 1'b0, 1,  0);
    run_op("asr2p",  3'b011, 16'h4000, 4'd2,  16'h1000, 1'b0, 3,  0);
    run_op("rol4",   3'b100, 16'hC003, 4'd4,  16'h003C, 1'b0, 5,  0);

    // Back-pressure, then a request accepted in the first IDLE cycle
    run_op("bp_lsl", 3'b001, 16'h8001, 4'd1,  16'h0002, 1'b1, 2,  10);
    run_op("bp_next", 3'b000, 16'h5A5A, 4'd7, 16'h5A5A, 1'b0, 1,  0);

    // Reset in the third SHIFT cycle of an amt-10 operation
    in_valid = 1'b1;
    in_op    = 3'b010;
    in_data  = 16'hFFFF;
    in_amt   = 4'd10;
    tick();  // accept, now in SHIFT cycle 1
    in_valid = 1'b0;
    tick();  // SHIFT cycle 2
    tick();  // SHIFT cycle 3
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 16'h0000);
    check("mid_rst_busy", busy, 0);
`ifdef SHIFTER_CARRY_EN
    check("mid_rst_carry", out_carry, 0);
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mid_rel_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    out_ready = 1'b0;
    check("mid_rst_no_valid", seen, 0);
    check("mid_rel_data", out_data, 16'h0000);
    run_op("post_pass", 3'b000, 16'h1234, 4'd0, 16'h1234, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, iterative shift unit: the multi-cycle successor to the 16-bit single-step datapath shifter. It accepts one operand per handshake and applies a shift or rotate of 0..WIDTH-1 bit positions, one position per clock. It returns the result over a valid/ready output channel. It sits between the operand register file and the writeback mux, and supports back-pressure from writeback.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- AMT_W, $clog2(WIDTH), width of the shift-amount field (derived; do not override).

Ports:
- clk  input  1  single clock, all state rises on posedge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_data  input  WIDTH  operand.
- in_op  input  3  operation code (see Operation).
- in_amt  input  AMT_W  shift amount.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_carry  output  1  last bit shifted/rotated out (only with SHIFTER_CARRY_EN).
- busy  output  1  high in SHIFT or DONE.

## Operation
- Op codes:
  - 000 PASS.
  - 001 LSL: zero fill at bit 0.
  - 010 LSR: zero fill at MSB.
  - 011 ASR: MSB replicated.
  - 100 ROL.
  - 101 ROR.
  - 110/111 reserved, executed as PASS.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, in_op and in_amt into the working register, op register and remaining-count register. Clear carry.
    - If amt==0 or op is PASS/reserved: go to DONE.
    - Otherwise: go to SHIFT.
  - SHIFT: each cycle, apply one single-position step of the latched op to the working register and decrement the count.
    - When count reaches 1, the step still executes and the next state is DONE.
  - DONE: out_valid=1, out_data = working register. Hold until out_ready, then return to IDLE.
    - No bypass: in_ready stays 0 in DONE, including the cycle out_ready is high.
- out_data and out_carry must remain stable while out_valid=1 and out_ready=0.
- Carry, updated on each step:
  - LSL: old MSB.
  - LSR/ASR: old bit 0.
  - ROL: old MSB, which equals the new bit 0.
  - ROR: old bit 0, which equals the new MSB.
  - PASS or amt==0: carry is 0.
- Reset values: in_ready=0 during reset, 1 in the first cycle after reset release; out_valid=0; out_data=0; out_carry=0; busy=0; state IDLE.
- Reset mid-operation: an in-flight request is discarded and no out_valid is produced.

## Timing
- Accept at cycle T.
- PASS/reserved/amt==0: out_valid rises at T+1.
- amt=n>0: SHIFT occupies T+1..T+n; out_valid rises at T+n+1.
- Worst-case latency: WIDTH cycles (amt=WIDTH-1).
- Throughput: one request per latency plus one handshake cycle. With out_ready held high, back-to-back PASS ops accept every 2 cycles.
- in_* values are sampled only on the accept edge; changes afterwards have no effect.

## Configuration
- SHIFTER_CARRY_EN defined: the out_carry port and the carry register exist, behaving as in Operation.
- SHIFTER_CARRY_EN undefined: the port and register are removed entirely. All other behaviour and latency are identical.

## Structure
- Package shifter_pkg contains:
  - Enum shift_op_e (3-bit codes above).
  - Enum shift_state_e (IDLE/SHIFT/DONE).
  - Function or constant for AMT_W.
- Sub-module shift_step: combinational one-position step. Parameter WIDTH; inputs data and op; outputs next_data and out_bit. Instantiated once in the FSM datapath.

## Test plan
All cases use WIDTH=16.
- LSL 0x8001, amt 1 -> out_data 0x0002, carry 1, out_valid at T+2.
- ASR 0x8000, amt 3 -> 0xF000, carry 0, out_valid at T+4. LSR of the same operand and amount -> 0x1000.
- LSR 0x8000, amt 15 -> 0x0001, carry 0, out_valid exactly at T+16. in_ready stays 0 throughout.
- ROL 0x8000, amt 1 -> 0x0001, carry 1. ROR 0x0001, amt 4 -> 0x1000. Reserved op 111 with 0xABCD, amt 5 -> 0xABCD at T+1, carry 0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_data/out_carry stable, in_ready=0. Raising out_ready returns the block to IDLE next cycle, and a new request is accepted in that IDLE cycle.
- Drive rst_n=0 in the 3rd SHIFT cycle of an amt-10 op -> no out_valid ever appears for that op. After release all outputs are at reset values and a fresh PASS 0x1234 completes correctly.
